// File: rtl/ordered_dither_pipe.sv
// Two-stage ordered-dither pipeline: Bayer threshold from pixel coordinates,
// with bypass, colour, mono and frame-rotated colour modes.
module ordered_dither_pipe #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 4,
    parameter int L       = 2,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic               i_frame_start,
    input  logic [1:0]         i_mode,
    input  logic [COORD_W-1:0] x_pixel,
    input  logic [COORD_W-1:0] y_pixel,
    input  logic [IN_W-1:0]    i_r,
    input  logic [IN_W-1:0]    i_g,
    input  logic [IN_W-1:0]    i_b,
    output logic               o_valid,
    output logic [OUT_W-1:0]   o_r,
    output logic [OUT_W-1:0]   o_g,
    output logic [OUT_W-1:0]   o_b,
    output logic [1:0]         o_mode
);
    localparam int T  = 2 * L;
    localparam int D  = IN_W - OUT_W;
    localparam int CW = IN_W + T;
    localparam logic [CW-1:0] RMASK = ((CW'(1) << D) - CW'(1)) << T;

    logic [1:0]      r_mode_q;
    logic [T-1:0]    r_fcnt;
    logic [1:0]      w_mode_e;
    logic [T-1:0]    w_fcnt_e;
    logic [L-1:0]    w_xe;
    logic [L-1:0]    w_ye;
    logic [T-1:0]    w_t;

    logic            r_s1_valid;
    logic [1:0]      r_s1_mode;
    logic [T-1:0]    r_s1_t;
    logic [IN_W-1:0] r_s1_r;
    logic [IN_W-1:0] r_s1_g;
    logic [IN_W-1:0] r_s1_b;

    logic [OUT_W-1:0] w_or;
    logic [OUT_W-1:0] w_og;
    logic [OUT_W-1:0] w_ob;
    logic             w_mono;

    assign w_mode_e = i_frame_start ? i_mode : r_mode_q;
    assign w_fcnt_e = i_frame_start ? r_fcnt + T'(1) : r_fcnt;
    assign o_mode   = r_mode_q;

    // Threshold bits interleave (x^y, y) per coordinate bit, LSB pair first
    always_comb begin
        w_xe = x_pixel[L-1:0];
        w_ye = y_pixel[L-1:0];
        if (w_mode_e == 2'd3) begin
            w_xe = x_pixel[L-1:0] + w_fcnt_e[L-1:0];
            w_ye = y_pixel[L-1:0] + w_fcnt_e[T-1:L];
        end
        w_t = '0;
        for (int b = 0; b < L; b++) begin
            w_t[T-1-2*b] = w_xe[b] ^ w_ye[b];
            w_t[T-2-2*b] = w_ye[b];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode_q <= '0;
            r_fcnt   <= '0;
        end else if (i_frame_start) begin
            r_mode_q <= i_mode;
            r_fcnt   <= w_fcnt_e;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= '0;
            r_s1_t     <= '0;
            r_s1_r     <= '0;
            r_s1_g     <= '0;
            r_s1_b     <= '0;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_mode <= w_mode_e;
                r_s1_t    <= w_t;
                r_s1_r    <= i_r;
                r_s1_g    <= i_g;
                r_s1_b    <= i_b;
            end
        end
    end

    // res > (t scaled to D bits) compared exactly as res*2^T > t*2^D
    function automatic logic [OUT_W-1:0] f_dither(
        input logic [IN_W-1:0] c,
        input logic [T-1:0]    t
    );
        logic [CW-1:0]  lhs;
        logic [CW-1:0]  rhs;
        logic [OUT_W:0] sum;
        lhs = (CW'(c) << T) & RMASK;
        rhs = CW'(t) << D;
        sum = {1'b0, c[IN_W-1 -: OUT_W]} + (OUT_W+1)'(lhs > rhs);
        return sum[OUT_W] ? '1 : sum[OUT_W-1:0];
    endfunction

    assign w_mono = r_s1_g[IN_W-1 -: T] > r_s1_t;

    always_comb begin
        w_or = f_dither(r_s1_r, r_s1_t);
        w_og = f_dither(r_s1_g, r_s1_t);
        w_ob = f_dither(r_s1_b, r_s1_t);
        case (r_s1_mode)
            2'd0: begin
                w_or = r_s1_r[IN_W-1 -: OUT_W];
                w_og = r_s1_g[IN_W-1 -: OUT_W];
                w_ob = r_s1_b[IN_W-1 -: OUT_W];
            end
            2'd2: begin
                w_or = {OUT_W{w_mono}};
                w_og = {OUT_W{w_mono}};
                w_ob = {OUT_W{w_mono}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_r     <= '0;
            o_g     <= '0;
            o_b     <= '0;
        end else begin
            o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                o_r <= w_or;
                o_g <= w_og;
                o_b <= w_ob;
            end
        end
    end
endmodule

// File: tb/tb_ordered_dither_pipe.sv
// Randomised and directed bench for ordered_dither_pipe against a
// coordinate-based Bayer reference model.
module tb_ordered_dither_pipe;
    localparam int IN_W = 8;
    localparam int OUT_W = 4;
    localparam int L = 2;
    localparam int COORD_W = 10;
    localparam int T = 2 * L;
    localparam int D = IN_W - OUT_W;
    localparam int N = 1 << L;
    localparam int OMAX = (1 << OUT_W) - 1;

    logic clk = 0;
    logic reset = 1;
    logic i_valid = 0;
    logic i_frame_start = 0;
    logic [1:0] i_mode = 0;
    logic [COORD_W-1:0] x_pixel = 0;
    logic [COORD_W-1:0] y_pixel = 0;
    logic [IN_W-1:0] i_r = 0;
    logic [IN_W-1:0] i_g = 0;
    logic [IN_W-1:0] i_b = 0;
    logic o_valid;
    logic [OUT_W-1:0] o_r;
    logic [OUT_W-1:0] o_g;
    logic [OUT_W-1:0] o_b;
    logic [1:0] o_mode;

    int n_cmp = 0;
    int n_bad = 0;

    int m_mode = 0;
    int m_fcnt = 0;
    int pv = 0, pr = 0, pg = 0, pb = 0;
    int hr = 0, hg = 0, hb = 0;

    ordered_dither_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .L(L), .COORD_W(COORD_W)
    ) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_frame_start(i_frame_start),
        .i_mode(i_mode), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_valid(o_valid), .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_mode(o_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int thr(input int xe, input int ye);
        int t = 0;
        for (int b = 0; b < L; b++) begin
            t += (((xe >> b) ^ (ye >> b)) & 1) << (T - 1 - 2 * b);
            t += ((ye >> b) & 1) << (T - 2 - 2 * b);
        end
        return t;
    endfunction

    function automatic int dith(input int c, input int t);
        int top = c >> D;
        int res = c % (1 << D);
        int ts = (D >= T) ? (t * (1 << (D - T))) : (t / (1 << (T - D)));
        int o = top + ((res > ts) ? 1 : 0);
        return (o > OMAX) ? OMAX : o;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_fcnt = 0;
        pv = 0; pr = 0; pg = 0; pb = 0;
        hr = 0; hg = 0; hb = 0;
    endtask

    task automatic step(input int v, input int fs, input int md,
                        input int x, input int y,
                        input int r, input int g, input int b);
        int me, xe, ye, t, nr, ng, nb;
        i_valid = v[0]; i_frame_start = fs[0]; i_mode = md[1:0];
        x_pixel = x[COORD_W-1:0]; y_pixel = y[COORD_W-1:0];
        i_r = r[IN_W-1:0]; i_g = g[IN_W-1:0]; i_b = b[IN_W-1:0];
        if (fs != 0) begin
            m_mode = md;
            m_fcnt = (m_fcnt + 1) % (1 << T);
        end
        me = m_mode;
        xe = x % N; ye = y % N;
        if (me == 3) begin
            xe = (xe + m_fcnt % N) % N;
            ye = (ye + m_fcnt / N) % N;
        end
        t = thr(xe, ye);
        case (me)
            0: begin nr = r >> D; ng = g >> D; nb = b >> D; end
            2: begin
                nr = ((g >> (IN_W - T)) > t) ? OMAX : 0;
                ng = nr; nb = nr;
            end
            default: begin nr = dith(r, t); ng = dith(g, t); nb = dith(b, t); end
        endcase
        @(posedge clk); #1;
        if (pv != 0) begin hr = pr; hg = pg; hb = pb; end
        chk("valid", int'(o_valid), pv);
        chk("r", int'(o_r), hr);
        chk("g", int'(o_g), hg);
        chk("b", int'(o_b), hb);
        chk("mode", int'(o_mode), m_mode);
        pv = v; pr = nr; pg = ng; pb = nb;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_r", int'(o_r), 0);
        chk("rst_mode", int'(o_mode), 0);
        reset = 0;

        // Bayer table spot checks of the model itself
        chk("thr_10", thr(1, 0), 8);
        chk("thr_31", thr(3, 1), 6);
        chk("thr_33", thr(3, 3), 5);

        // mono via frame start on a valid pixel
        step(1, 1, 2, 1, 0, 0, 8'h80, 0);
        step(1, 0, 0, 2, 0, 0, 8'h80, 0);
        chk("t1_lo", int'(o_g), 0);
        idle();
        chk("t1_hi", int'(o_r), 15);

        // colour dither and saturation
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 8'h37, 0, 0);
        step(1, 0, 0, 1, 0, 8'h37, 0, 0);
        chk("t2_00", int'(o_r), 4);
        step(1, 0, 0, 0, 0, 8'hFF, 0, 0);
        chk("t2_10", int'(o_r), 3);
        idle();
        chk("t2_sat", int'(o_r), 15);

        // bypass over all matrix positions
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            step(1, 0, 0, i % 4, i / 4, 8'hA5, 8'h3C, 8'h0F);
        idle();
        chk("t3_byp", int'(o_r), 10);
        idle();
        chk("t3_drain", int'(o_valid), 0);

        // mode change without frame start is ignored
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 2, 0, 0, 8'h37, 8'h80, 0);
        step(1, 0, 2, 1, 0, 8'h37, 8'h80, 0);
        chk("t4_mode", int'(o_mode), 1);
        chk("t4_col", int'(o_r), 4);
        step(1, 1, 2, 2, 0, 0, 8'h80, 0);
        idle();
        idle();
        chk("t4_mono", int'(o_g), 15);

        // reset with pixels in flight
        step(1, 0, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF);
        step(1, 0, 0, 1, 0, 8'hFF, 8'hFF, 8'hFF);
        reset = 1;
        #1;
        chk("t6_valid", int'(o_valid), 0);
        chk("t6_r", int'(o_r), 0);
        chk("t6_mode", int'(o_mode), 0);
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        repeat (3) idle();

        // temporal rotation from fresh counter
        step(1, 1, 3, 0, 0, 8'h37, 0, 0);
        idle();
        chk("t5_f1", int'(o_r), 3);
        step(1, 1, 3, 0, 0, 8'h37, 0, 0);
        idle();
        chk("t5_f2", int'(o_r), 4);

        // random traffic, includes fcnt wrap and idle frame starts
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0 ? 1 : 0,
                 ($urandom % 12) == 0 ? 1 : 0,
                 int'($urandom % 4),
                 int'($urandom % (1 << COORD_W)),
                 int'($urandom % (1 << COORD_W)),
                 int'($urandom % 256), int'($urandom % 256),
                 int'($urandom % 256));
        end
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
